// File: rtl/spi_xfer_ctrl_if.sv
// Request/response handshake between two requesters and the shared SPI transfer controller.
interface spi_xfer_ctrl_if #(
   parameter int SIZE = 40
);
   logic [1:0]      req_valid;
   logic [SIZE-1:0] req_data0;
   logic [SIZE-1:0] req_data1;
   logic [1:0]      req_ready;
   logic [1:0]      rsp_valid;
   logic [SIZE-1:0] rsp_data;

   modport master (
      output req_valid, req_data0, req_data1,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_data0, req_data1,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// Round-robin arbiter sharing one MSB-first SPI mode-3 shift engine between two requesters.
// Define SPI_CS_PER_REQ_EN to give each requester its own chip select; otherwise cs_n_out is shared.
module spi_xfer_ctrl #(
   parameter int SIZE     = 40,
   parameter int DIV      = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 2
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   spi_xfer_ctrl_if.slave    bus,
   output logic              busy_out,
   output logic              sck_out,
`ifdef SPI_CS_PER_REQ_EN
   output logic [1:0]        cs_n_out,
`else
   output logic              cs_n_out,
`endif
   output logic              mosi_out,
   input  logic              miso_in
);

`ifdef SPI_CS_PER_REQ_EN
   localparam int CS_W = 2;
`else
   localparam int CS_W = 1;
`endif
   localparam int TMAX   = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                                                : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
   localparam int TMR_W  = $clog2(TMAX + 1);
   localparam int HALF_W = $clog2(DIV + 1);
   localparam int BIT_W  = $clog2(SIZE + 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t            state_q, state_d;
   logic [SIZE-1:0]   tx_q, tx_d;
   logic [SIZE-1:0]   rx_q, rx_d;
   logic [SIZE-1:0]   rsp_data_q, rsp_data_d;
   logic [1:0]        rsp_valid_q, rsp_valid_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [HALF_W-1:0] half_q, half_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [CS_W-1:0]   cs_n_q, cs_n_d;
   logic              sck_q, sck_d;
   logic              mosi_q, mosi_d;
   logic              grant_q, grant_d;
   logic              rr_q, rr_d;
   logic [1:0]        ready;
   logic              win;

   // rr_q names the requester preferred on a tie: the one not granted last.
   always_comb begin
      ready = 2'b00;
      if (state_q == IDLE) begin
         if (bus.req_valid == 2'b11) ready = rr_q ? 2'b10 : 2'b01;
         else                        ready = bus.req_valid;
      end
   end

   assign win = ready[1];

   always_comb begin
      state_d     = state_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = 2'b00;
      tmr_d       = tmr_q;
      half_d      = half_q;
      bit_d       = bit_q;
      cs_n_d      = cs_n_q;
      sck_d       = sck_q;
      mosi_d      = mosi_q;
      grant_d     = grant_q;
      rr_d        = rr_q;
      unique case (state_q)
         IDLE: begin
            if (|ready) begin
               tx_d    = win ? bus.req_data1 : bus.req_data0;
               mosi_d  = tx_d[SIZE-1];
               grant_d = win;
               rr_d    = ~win;
               tmr_d   = '0;
`ifdef SPI_CS_PER_REQ_EN
               cs_n_d  = win ? 2'b01 : 2'b10;
`else
               cs_n_d  = 1'b0;
`endif
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (tmr_q == TMR_W'(CS_SETUP - 1)) begin
               sck_d   = 1'b0;
               half_d  = '0;
               bit_d   = '0;
               state_d = SHIFT;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         SHIFT: begin
            // The last bit's high half belongs to SHIFT; HOLD starts where the next fall would be.
            if (half_q == HALF_W'(DIV - 1)) begin
               half_d = '0;
               if (!sck_q) begin
                  sck_d   = 1'b1;
                  rx_d    = rx_q << 1;
                  rx_d[0] = miso_in;
                  bit_d   = bit_q + 1'b1;
               end else if (bit_q == BIT_W'(SIZE)) begin
                  tmr_d   = '0;
                  state_d = HOLD;
               end else begin
                  sck_d  = 1'b0;
                  tx_d   = tx_q << 1;
                  mosi_d = tx_d[SIZE-1];
               end
            end else begin
               half_d = half_q + 1'b1;
            end
         end
         HOLD: begin
            if (tmr_q == TMR_W'(CS_HOLD - 1)) begin
               cs_n_d               = '1;
               mosi_d               = 1'b0;
               rsp_data_d           = rx_q;
               rsp_valid_d[grant_q] = 1'b1;
               tmr_d                = '0;
               state_d              = GAP;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         GAP: begin
            if (tmr_q == TMR_W'(CS_IDLE - 1)) state_d = IDLE;
            else                              tmr_d   = tmr_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= IDLE;
         tx_q        <= '0;
         rx_q        <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 2'b00;
         tmr_q       <= '0;
         half_q      <= '0;
         bit_q       <= '0;
         cs_n_q      <= '1;
         sck_q       <= 1'b1;
         mosi_q      <= 1'b0;
         grant_q     <= 1'b0;
         rr_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         tmr_q       <= tmr_d;
         half_q      <= half_d;
         bit_q       <= bit_d;
         cs_n_q      <= cs_n_d;
         sck_q       <= sck_d;
         mosi_q      <= mosi_d;
         grant_q     <= grant_d;
         rr_q        <= rr_d;
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign busy_out      = (state_q != IDLE);
   assign sck_out       = sck_q;
   assign cs_n_out      = cs_n_q;
   assign mosi_out      = mosi_q;

endmodule
